// File: rtl/cpu_run_ctrl.sv
// Run controller for the Y86 core: decides when execution stops from retired
// status codes, latches the terminating status and keeps saturating counters.
module cpu_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic [1:0]       stat_i,
  input  logic             stat_valid_i,
  output logic             run_o,
  output logic             done_o,
  output logic             done_pulse_o,
  output logic [1:0]       final_stat_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [1:0]       STAT_AOK = 2'b00;
  localparam logic [1:0]       STAT_HLT = 2'b01;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(MAX_CYCLES - 1);

  state_e           state_q, state_d;
  logic             run_q, run_d;
  logic             done_q, done_d;
  logic             done_pulse_q, done_pulse_d;
  logic [1:0]       final_stat_q, final_stat_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic             bad_stat;
  logic             retire;
  logic             wd_hit;

  assign bad_stat = stat_valid_i && (stat_i != STAT_AOK);
  assign retire   = stat_valid_i && ((stat_i == STAT_AOK) || (stat_i == STAT_HLT));
  // The watchdog fires on the cycle whose increment brings the count to MAX_CYCLES.
  assign wd_hit   = (MAX_CYCLES != 0) && (cycle_cnt_q == WD_LAST);

  always_comb begin
    state_d      = state_q;
    done_pulse_d = 1'b0;
    final_stat_d = final_stat_q;
    timeout_d    = timeout_q;
    cycle_cnt_d  = cycle_cnt_q;
    instr_cnt_d  = instr_cnt_q;

    case (state_q)
      IDLE: begin
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (cycle_cnt_q != CNT_MAX) cycle_cnt_d = cycle_cnt_q + 1'b1;
        if (retire && (instr_cnt_q != CNT_MAX)) instr_cnt_d = instr_cnt_q + 1'b1;
        if (bad_stat) begin
          state_d      = DONE;
          final_stat_d = stat_i;
          timeout_d    = 1'b0;
          done_pulse_d = 1'b1;
        end else if (wd_hit) begin
          state_d      = DONE;
          final_stat_d = STAT_AOK;
          timeout_d    = 1'b1;
          done_pulse_d = 1'b1;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (clear_i) begin
      state_d      = IDLE;
      done_pulse_d = 1'b0;
      final_stat_d = STAT_AOK;
      timeout_d    = 1'b0;
      cycle_cnt_d  = '0;
      instr_cnt_d  = '0;
    end

    // Status outputs are registered copies of the next state.
    run_d  = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
      done_pulse_q <= 1'b0;
      final_stat_q <= 2'b00;
      timeout_q    <= 1'b0;
      cycle_cnt_q  <= '0;
      instr_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      run_q        <= run_d;
      done_q       <= done_d;
      done_pulse_q <= done_pulse_d;
      final_stat_q <= final_stat_d;
      timeout_q    <= timeout_d;
      cycle_cnt_q  <= cycle_cnt_d;
      instr_cnt_q  <= instr_cnt_d;
    end
  end

  assign run_o        = run_q;
  assign done_o       = done_q;
  assign done_pulse_o = done_pulse_q;
  assign final_stat_o = final_stat_q;
  assign timeout_o    = timeout_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign instr_cnt_o  = instr_cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed testbench for cpu_run_ctrl: three instances (default, watchdog=10,
// 4-bit counters) share one stimulus stream and are checked per scenario.
module tb_cpu_run_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       clear;
  logic [1:0] stat;
  logic       stat_valid;

  logic        a_run, a_done, a_pulse, a_timeout;
  logic [1:0]  a_final;
  logic [31:0] a_cycle, a_instr;

  logic        w_run, w_done, w_pulse, w_timeout;
  logic [1:0]  w_final;
  logic [31:0] w_cycle, w_instr;

  logic        s_run, s_done, s_pulse, s_timeout;
  logic [1:0]  s_final;
  logic [3:0]  s_cycle, s_instr;

  int checks;
  int errors;

  cpu_run_ctrl #(.CNT_W(32), .MAX_CYCLES(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
    .stat_i(stat), .stat_valid_i(stat_valid),
    .run_o(a_run), .done_o(a_done), .done_pulse_o(a_pulse),
    .final_stat_o(a_final), .timeout_o(a_timeout),
    .cycle_cnt_o(a_cycle), .instr_cnt_o(a_instr)
  );

  cpu_run_ctrl #(.CNT_W(32), .MAX_CYCLES(10)) dut_w (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
    .stat_i(stat), .stat_valid_i(stat_valid),
    .run_o(w_run), .done_o(w_done), .done_pulse_o(w_pulse),
    .final_stat_o(w_final), .timeout_o(w_timeout),
    .cycle_cnt_o(w_cycle), .instr_cnt_o(w_instr)
  );

  cpu_run_ctrl #(.CNT_W(4), .MAX_CYCLES(0)) dut_s (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .clear_i(clear),
    .stat_i(stat), .stat_valid_i(stat_valid),
    .run_o(s_run), .done_o(s_done), .done_pulse_o(s_pulse),
    .final_stat_o(s_final), .timeout_o(s_timeout),
    .cycle_cnt_o(s_cycle), .instr_cnt_o(s_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge and settle; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; clear = 1'b0; stat = 2'b00; stat_valid = 1'b0;
    #12;
    checks++;
    if ({a_run, a_done, a_pulse, a_final, a_timeout} !== 6'b0 || a_cycle !== 32'd0 || a_instr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got run=%0b done=%0b pulse=%0b final=%0h to=%0b cyc=%0d ins=%0d expected all 0",
               a_run, a_done, a_pulse, a_final, a_timeout, a_cycle, a_instr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_idle();
    start = 1'b1; clear = 1'b1; stat = 2'b01; stat_valid = 1'b1;
    step();
    clear = 1'b0; start = 1'b0;
    step();
    stat_valid = 1'b0;
    checks++;
    if (a_run !== 1'b0 || a_done !== 1'b0 || a_instr !== 32'd0) begin
      errors++;
      $display("FAIL idle_start_clear: got run=%0b done=%0b ins=%0d expected 0 0 0", a_run, a_done, a_instr);
    end
  endtask

  task automatic test_halt();
    int run_seen;
    run_seen = 0;
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    if (a_run === 1'b1) run_seen++;
    for (int i = 0; i < 6; i++) begin
      stat_valid = 1'b1;
      stat = (i == 5) ? 2'b01 : 2'b00;
      step();
      if (a_run === 1'b1) run_seen++;
    end
    stat_valid = 1'b0;
    checks++;
    if (run_seen !== 5 + 1 - 1 + 1) begin
      errors++;
      $display("FAIL halt_run_cycles: got %0d expected 6", run_seen);
    end
    checks++;
    if (a_done !== 1'b1 || a_pulse !== 1'b1 || a_run !== 1'b0) begin
      errors++;
      $display("FAIL halt_done_entry: got done=%0b pulse=%0b run=%0b expected 1 1 0", a_done, a_pulse, a_run);
    end
    checks++;
    if (a_final !== 2'b01 || a_timeout !== 1'b0 || a_instr !== 32'd6 || a_cycle !== 32'd6) begin
      errors++;
      $display("FAIL halt_status: got final=%0h to=%0b ins=%0d cyc=%0d expected 1 0 6 6", a_final, a_timeout, a_instr, a_cycle);
    end
    step();
    checks++;
    if (a_pulse !== 1'b0 || a_done !== 1'b1 || a_cycle !== 32'd6) begin
      errors++;
      $display("FAIL halt_pulse_fall: got pulse=%0b done=%0b cyc=%0d expected 0 1 6", a_pulse, a_done, a_cycle);
    end
  endtask

  task automatic test_ins();
    do_clear();
    checks++;
    if (a_done !== 1'b0 || a_final !== 2'b00 || a_cycle !== 32'd0 || a_instr !== 32'd0) begin
      errors++;
      $display("FAIL clear_after_done: got done=%0b final=%0h cyc=%0d ins=%0d expected 0 0 0 0", a_done, a_final, a_cycle, a_instr);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      stat_valid = 1'b1;
      stat = (i == 3) ? 2'b11 : 2'b00;
      step();
    end
    stat_valid = 1'b0;
    checks++;
    if (a_final !== 2'b11 || a_instr !== 32'd3 || a_cycle !== 32'd4 || a_done !== 1'b1) begin
      errors++;
      $display("FAIL ins_stop: got final=%0h ins=%0d cyc=%0d done=%0b expected 3 3 4 1", a_final, a_instr, a_cycle, a_done);
    end
    start = 1'b1;
    step();
    step();
    start = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_run !== 1'b0 || a_cycle !== 32'd4) begin
      errors++;
      $display("FAIL done_ignores_start: got done=%0b run=%0b cyc=%0d expected 1 0 4", a_done, a_run, a_cycle);
    end
  endtask

  task automatic test_watchdog();
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    checks++;
    if (w_done !== 1'b0 || w_run !== 1'b1 || w_cycle !== 32'd9) begin
      errors++;
      $display("FAIL wd_before_limit: got done=%0b run=%0b cyc=%0d expected 0 1 9", w_done, w_run, w_cycle);
    end
    step();
    checks++;
    if (w_done !== 1'b1 || w_pulse !== 1'b1 || w_timeout !== 1'b1 || w_final !== 2'b00 || w_cycle !== 32'd10) begin
      errors++;
      $display("FAIL wd_timeout: got done=%0b pulse=%0b to=%0b final=%0h cyc=%0d expected 1 1 1 0 10",
               w_done, w_pulse, w_timeout, w_final, w_cycle);
    end
    checks++;
    if (a_run !== 1'b1 || a_done !== 1'b0 || a_cycle !== 32'd10) begin
      errors++;
      $display("FAIL no_wd_keeps_running: got run=%0b done=%0b cyc=%0d expected 1 0 10", a_run, a_done, a_cycle);
    end
  endtask

  task automatic test_wd_vs_status();
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    stat_valid = 1'b1;
    stat = 2'b10;
    step();
    stat_valid = 1'b0;
    checks++;
    if (w_done !== 1'b1 || w_final !== 2'b10 || w_timeout !== 1'b0 || w_cycle !== 32'd10 || w_instr !== 32'd0) begin
      errors++;
      $display("FAIL wd_status_wins: got done=%0b final=%0h to=%0b cyc=%0d ins=%0d expected 1 2 0 10 0",
               w_done, w_final, w_timeout, w_cycle, w_instr);
    end
  endtask

  task automatic test_saturate();
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    stat_valid = 1'b1;
    stat = 2'b00;
    for (int i = 0; i < 20; i++) step();
    stat_valid = 1'b0;
    checks++;
    if (s_instr !== 4'd15 || s_cycle !== 4'd15 || s_run !== 1'b1) begin
      errors++;
      $display("FAIL sat_4bit: got ins=%0d cyc=%0d run=%0b expected 15 15 1", s_instr, s_cycle, s_run);
    end
    checks++;
    if (a_instr !== 32'd20 || a_cycle !== 32'd20) begin
      errors++;
      $display("FAIL wide_counts: got ins=%0d cyc=%0d expected 20 20", a_instr, a_cycle);
    end
    do_clear();
    checks++;
    if ({s_run, s_done, s_pulse, s_final, s_timeout} !== 6'b0 || s_instr !== 4'd0 || s_cycle !== 4'd0) begin
      errors++;
      $display("FAIL sat_clear: got run=%0b done=%0b pulse=%0b final=%0h to=%0b ins=%0d cyc=%0d expected all 0",
               s_run, s_done, s_pulse, s_final, s_timeout, s_instr, s_cycle);
    end
    step();
    checks++;
    if (s_run !== 1'b0 || s_cycle !== 4'd0) begin
      errors++;
      $display("FAIL sat_clear_idle: got run=%0b cyc=%0d expected 0 0", s_run, s_cycle);
    end
  endtask

  task automatic test_async_reset();
    do_clear();
    start = 1'b1;
    step();
    start = 1'b0;
    stat_valid = 1'b1;
    stat = 2'b00;
    for (int i = 0; i < 3; i++) step();
    stat_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_run !== 1'b0 || a_cycle !== 32'd0 || a_instr !== 32'd0 || a_final !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: got run=%0b cyc=%0d ins=%0d final=%0h expected 0 0 0 0", a_run, a_cycle, a_instr, a_final);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    stat_valid = 1'b1;
    stat = 2'b00;
    step();
    stat_valid = 1'b0;
    checks++;
    if (a_run !== 1'b1 || a_cycle !== 32'd1 || a_instr !== 32'd1) begin
      errors++;
      $display("FAIL restart_after_reset: got run=%0b cyc=%0d ins=%0d expected 1 1 1", a_run, a_cycle, a_instr);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_idle();
    test_halt();
    test_ins();
    test_watchdog();
    test_wd_vs_status();
    test_saturate();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
